// File: rtl/alu_mc.sv
// Handshaked execute-stage ALU: single-cycle RV32I ops plus an iterative
// shift-add multiplier / restoring divider for RV32M.
module alu_mc #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      funct3_in,
  input  logic [6:0]      funct7_in,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] mux_result_in,
  output logic            result_valid_out,
  input  logic            result_ready_in,
  output logic [XLEN-1:0] result_out,
  output logic            illegal_out
);

  localparam int SW = $clog2(XLEN);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              illegal_q;
  logic [2*XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0]   addend_q;
  logic              neg_q;
  logic [2:0]        f3_q;

  logic            accept;
  logic [XLEN-1:0] a, b;
  logic [SW-1:0]   shamt;
  logic            alt, lt, ltu, taken;
  logic [XLEN-1:0] alu_res, single_res;
  logic            illegal, start_m;
  logic            a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  assign a     = rs1_value_in;
  assign b     = mux_result_in;
  assign shamt = b[SW-1:0];

  // Decode and single-cycle datapath
  always_comb begin
    alt = funct7_in[5] & ((opcode_in == OPC_OP) | (funct3_in == 3'b101));
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    case (funct3_in)
      3'b000:  alu_res = alt ? (a - b) : (a + b);
      3'b001:  alu_res = a << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, ltu};
      3'b100:  alu_res = a ^ b;
      3'b101:  alu_res = alt ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
      3'b110:  alu_res = a | b;
      default: alu_res = a & b;
    endcase
    case (funct3_in)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      default: taken = ~ltu;
    endcase

    a_signed = (funct3_in == 3'b001) | (funct3_in == 3'b010) |
               (funct3_in == 3'b100) | (funct3_in == 3'b110);
    b_signed = (funct3_in == 3'b001) | (funct3_in == 3'b100) | (funct3_in == 3'b110);
    neg_a = a_signed & a[XLEN-1];
    neg_b = b_signed & b[XLEN-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;

    single_res = '0;
    illegal    = 1'b0;
    start_m    = 1'b0;
    case (opcode_in)
      OPC_OP: begin
        if (funct7_in == 7'b0000000) begin
          single_res = alu_res;
        end else if (funct7_in == 7'b0100000 &&
                     (funct3_in == 3'b000 || funct3_in == 3'b101)) begin
          single_res = alu_res;
        end else if (funct7_in == 7'b0000001 && ENABLE_M) begin
          // Divide corner cases finish immediately
          if (funct3_in[2] && b == '0)
            single_res = funct3_in[1] ? a : '1;
          else if (funct3_in[2] && b_signed && a == MIN_NEG && b == '1)
            single_res = funct3_in[1] ? '0 : a;
          else
            start_m = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_IMM: begin
        if (funct3_in == 3'b001 && funct7_in != 7'b0000000)
          illegal = 1'b1;
        else if (funct3_in == 3'b101 && funct7_in != 7'b0000000 && funct7_in != 7'b0100000)
          illegal = 1'b1;
        else
          single_res = alu_res;
      end
      OPC_LUI:              single_res = b;
      OPC_LOAD, OPC_STORE:  single_res = a + b;
      OPC_BR: begin
        if (funct3_in[2:1] == 2'b01) illegal = 1'b1;
        else single_res = {{(XLEN-1){1'b0}}, taken};
      end
      default: illegal = 1'b1;
    endcase
  end

  // Iterative engine: work_q is {acc_hi, multiplier} or {remainder, quotient}
  logic [XLEN:0]     msum, shifted, dsub;
  logic [2*XLEN-1:0] mul_next, div_next, prod_s;
  logic [XLEN-1:0]   qr, m_res;
  logic              ge;

  always_comb begin
    msum     = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, addend_q} : '0);
    mul_next = {msum, work_q[XLEN-1:1]};
    shifted  = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    dsub     = shifted - {1'b0, addend_q};
    ge       = ~dsub[XLEN];
    div_next = {(ge ? dsub[XLEN-1:0] : shifted[XLEN-1:0]), work_q[XLEN-2:0], ge};
    work_d   = f3_q[2] ? div_next : mul_next;
    prod_s   = neg_q ? -work_d : work_d;
    qr       = f3_q[1] ? work_d[2*XLEN-1:XLEN] : work_d[XLEN-1:0];
    if (f3_q[2])
      m_res = neg_q ? -qr : qr;
    else
      m_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = start_m ? S_BUSY : S_DONE;
      S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE: begin
        if (accept)               state_d = start_m ? S_BUSY : S_DONE;
        else if (result_ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_out        = (state_q == S_IDLE) | ((state_q == S_DONE) & result_ready_in);
    result_valid_out = (state_q == S_DONE);
    accept           = valid_in & ready_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      work_q    <= '0;
      addend_q  <= '0;
      neg_q     <= 1'b0;
      f3_q      <= '0;
    end else if (accept) begin
      illegal_q <= illegal;
      if (start_m) begin
        cnt_q    <= SW'(XLEN-1);
        f3_q     <= funct3_in;
        neg_q    <= (funct3_in[2] & funct3_in[1]) ? neg_a : (neg_a ^ neg_b);
        work_q   <= funct3_in[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
        addend_q <= funct3_in[2] ? mag_b : mag_a;
      end else begin
        result_q <= single_res;
      end
    end else if (state_q == S_BUSY) begin
      work_q <= work_d;
      cnt_q  <= cnt_q - SW'(1);
      if (cnt_q == '0) result_q <= m_res;
    end
  end

  assign result_out  = result_q;
  assign illegal_out = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results queued at issue, compared as
// the DUT hands them over; a second instance covers ENABLE_M=0.
module tb_alu_mc;
  localparam logic [6:0] OP = 7'b0110011, IMM = 7'b0010011, LUI = 7'b0110111;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011;
  localparam logic [6:0] F0 = 7'b0000000, F1 = 7'b0000001, F20 = 7'b0100000;

  logic        clk = 1'b0;
  logic        rst, valid_in, ready_out, result_ready_in;
  logic [6:0]  opcode_in, funct7_in;
  logic [2:0]  funct3_in;
  logic [31:0] rs1_value_in, mux_result_in, result_out;
  logic        result_valid_out, illegal_out;
  logic        u1_rdy, u1_vld, u1_ill;
  logic [31:0] u1_res;

  alu_mc #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .opcode_in(opcode_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
    .rs1_value_in(rs1_value_in), .mux_result_in(mux_result_in),
    .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
    .result_out(result_out), .illegal_out(illegal_out));

  alu_mc #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(u1_rdy),
    .opcode_in(opcode_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
    .rs1_value_in(rs1_value_in), .mux_result_in(mux_result_in),
    .result_valid_out(u1_vld), .result_ready_in(result_ready_in),
    .result_out(u1_res), .illegal_out(u1_ill));

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] res; logic ill;} exp_t;
  exp_t sb_q[$];
  int errors = 0, checks = 0, cyc = 0, acc_cyc = 0, ops = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && result_valid_out && result_ready_in) begin
      if (sb_q.size() == 0) begin
        check("sb_extra", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res", result_out, e.res);
        check("ill", {31'b0, illegal_out}, {31'b0, e.ill});
      end
    end
  end

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic ill, input bit push);
    int n = 0;
    exp_t e;
    opcode_in = opc; funct3_in = f3; funct7_in = f7;
    rs1_value_in = a; mux_result_in = b; valid_in = 1'b1;
    while (!ready_out && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("accept_timeout", n, 0);
    if (push) begin
      e.res = exp; e.ill = ill;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    acc_cyc = cyc - 1;
    valid_in = 1'b0;
    ops++;
  endtask

  task automatic wait_result(input int exp_lat);
    int n = 0;
    bit rdy_seen = 0;
    while (!result_valid_out && n < 100) begin
      if (ready_out) rdy_seen = 1;
      @(posedge clk); #1; n++;
    end
    check("latency", cyc - acc_cyc, exp_lat);
    if (exp_lat > 1) check("busy_ready", {31'b0, rdy_seen}, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("drain", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int start_cyc, start_ops;
    rst = 1'b1; valid_in = 1'b0; result_ready_in = 1'b1;
    opcode_in = '0; funct3_in = '0; funct7_in = '0;
    rs1_value_in = '0; mux_result_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, result_valid_out}, 0);
    check("rst_result", result_out, 0);
    check("rst_illegal", {31'b0, illegal_out}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", {31'b0, ready_out}, 1);

    // Reset in the middle of a divide
    issue(LUI, 3'b000, F0, 32'd0, 32'h1234_5000, 32'h1234_5000, 1'b0, 1);
    wait_result(1);
    issue(OP, 3'b100, F1, 32'd100, 32'd7, 32'd0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    check("mid_div_ready", {31'b0, ready_out}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", {31'b0, result_valid_out}, 0);
    check("midrst_result", result_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", {31'b0, ready_out}, 1);
    issue(OP, 3'b000, F0, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    wait_result(1);
    drain();

    // Back-to-back RV32I sweep
    start_cyc = cyc; start_ops = ops;
    issue(OP,  3'b000, F20, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
    issue(IMM, 3'b101, F20, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
    issue(OP,  3'b011, F0, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1);
    issue(BR,  3'b100, F0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    issue(OP,  3'b111, F0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
    issue(OP,  3'b110, F0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1);
    issue(OP,  3'b100, F0, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1);
    issue(OP,  3'b001, F0, 32'd1, 32'd35, 32'd8, 1'b0, 1);
    issue(OP,  3'b101, F0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);
    issue(OP,  3'b010, F0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    issue(OP,  3'b011, F0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    issue(IMM, 3'b000, F20, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    issue(IMM, 3'b010, F0, 32'hFFFF_FFF0, 32'd3, 32'd1, 1'b0, 1);
    issue(LD,  3'b010, F0, 32'h0000_1000, 32'h10, 32'h0000_1010, 1'b0, 1);
    issue(ST,  3'b010, F0, 32'h0000_2000, 32'hFFFF_FFFC, 32'h0000_1FFC, 1'b0, 1);
    issue(BR,  3'b000, F0, 32'd5, 32'd6, 32'd0, 1'b0, 1);
    issue(BR,  3'b001, F0, 32'd5, 32'd6, 32'd1, 1'b0, 1);
    issue(BR,  3'b111, F0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    issue(BR,  3'b101, F0, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1);
    check("throughput", cyc - start_cyc, ops - start_ops);
    drain();

    // Multiply, latency XLEN+1
    issue(OP, 3'b001, F1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1);
    wait_result(33);
    issue(OP, 3'b010, F1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 1);
    wait_result(33);
    issue(OP, 3'b011, F1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1);
    wait_result(33);
    issue(OP, 3'b000, F1, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0, 1);
    check("nom_valid", {31'b0, u1_vld}, 1);
    check("nom_illegal", {31'b0, u1_ill}, 1);
    check("nom_result", u1_res, 0);
    check("nom_ready", {31'b0, u1_rdy}, 1);
    wait_result(33);

    // Divide corners (latency 1) and normal divides
    issue(OP, 3'b100, F1, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    wait_result(1);
    issue(OP, 3'b111, F1, 32'd7, 32'd0, 32'd7, 1'b0, 1);
    wait_result(1);
    issue(OP, 3'b100, F1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    wait_result(1);
    issue(OP, 3'b110, F1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    wait_result(1);
    issue(OP, 3'b100, F1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1);
    wait_result(33);
    issue(OP, 3'b110, F1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1);
    wait_result(33);
    issue(OP, 3'b101, F1, 32'd100, 32'd7, 32'd14, 1'b0, 1);
    wait_result(33);
    issue(OP, 3'b111, F1, 32'd100, 32'd7, 32'd2, 1'b0, 1);
    wait_result(33);
    drain();

    // Backpressure
    result_ready_in = 1'b0;
    issue(OP, 3'b100, F0, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_result", result_out, 32'h5A5A_A5A5);
      check("bp_ready", {31'b0, ready_out}, 0);
      check("bp_valid", {31'b0, result_valid_out}, 1);
      @(posedge clk); #1;
    end
    result_ready_in = 1'b1;
    drain();

    // Illegal encodings
    issue(7'b1111111, 3'b000, F0, 32'd1, 32'd2, 32'd0, 1'b1, 1);
    wait_result(1);
    issue(OP,  3'b100, F20, 32'd1, 32'd2, 32'd0, 1'b1, 1);
    issue(IMM, 3'b001, F20, 32'd1, 32'd2, 32'd0, 1'b1, 1);
    issue(BR,  3'b010, F0, 32'd1, 32'd1, 32'd0, 1'b1, 1);
    issue(OP,  3'b000, 7'b0000011, 32'd1, 32'd2, 32'd0, 1'b1, 1);
    issue(OP,  3'b000, F0, 32'd1, 32'd2, 32'd3, 1'b0, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, handshaked successor to the combinational execute-stage ALU.
- Implements the complete RV32I integer operation set: OP, OP-IMM, LUI pass-through, load/store address add and branch compare.
- Adds an iterative RV32M multiply/divide engine.
- Sits between the operand mux and the writeback/branch logic, using valid/ready on both sides so the multi-cycle ops can stall the pipeline.

Parameters:
- XLEN, 32, datapath width. Must be a power of two, ≥8. Shift amount width is log2(XLEN).
- ENABLE_M, 1, when 1 the M-extension ops are executed; when 0 they are reported as illegal.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- valid_in  input  1  operation presented.
- ready_out  output  1  block can accept an operation this cycle.
- opcode_in  input  7  RISC-V opcode.
- funct3_in  input  3  RISC-V funct3.
- funct7_in  input  7  RISC-V funct7.
- rs1_value_in  input  XLEN  operand A.
- mux_result_in  input  XLEN  operand B (rs2 or immediate).
- result_valid_out  output  1  result_out is valid.
- result_ready_in  input  1  consumer takes the result.
- result_out  output  XLEN  result; for branches, bit0 = taken, other bits 0.
- illegal_out  output  1  qualifies result_valid_out; the op was unsupported.

Behaviour:
- Reset (async, any state, including mid-iteration):
  - State goes to IDLE and any in-flight op is discarded.
  - result_out=0, result_valid_out=0, illegal_out=0.
  - ready_out=1 from the first clk edge after rst deasserts.
- States: IDLE, BUSY, DONE.
- ready_out = (state==IDLE) | (state==DONE & result_ready_in). An accept occurs on an edge where valid_in & ready_out.
- Single-cycle ops (latency 1):
  - Accept moves the block to DONE with the result registered.
  - result_valid_out is high in the next cycle.
  - A new op may be accepted on the same edge the previous result is consumed, giving back-to-back throughput of 1/cycle.
- Op decode:
  - 0110011 with funct7=0000000 or 0100000: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. funct7 bit5 selects SUB/SRA.
  - 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI.
    - funct7 is only consulted for funct3 001/101, where bit5 selects SRAI.
    - SLLI requires funct7=0000000; SRLI/SRAI require 0000000 or 0100000. Other funct7 values are illegal.
  - 0110111 (LUI): result = mux_result_in.
  - 0000011 and 0100011 (load/store): result = A+B.
  - 1100011 (branch): BEQ, BNE, BLT, BGE, BLTU, BGEU. funct3 010/011 are illegal.
  - Shift amount = B[log2(XLEN)-1:0]. SRA/SRAI sign-fill.
  - Arithmetic wraps modulo 2^XLEN. SLT/SLTU return 0 or 1.
- M ops (opcode 0110011, funct7 0000001, ENABLE_M=1):
  - MUL, MULH, MULHSU, MULHU use a shift-add multiplier over the operand magnitudes, followed by sign correction.
  - DIV, DIVU, REM, REMU use a restoring divider over the magnitudes, followed by sign correction.
  - State goes to BUSY with an iteration counter loaded to XLEN-1. The counter decrements once per cycle; leaving BUSY at count 0 enters DONE.
  - Latency is fixed at XLEN+1 edges from accept to result_valid_out.
  - ready_out=0 throughout BUSY.
  - Special cases complete with latency 1 and never enter BUSY:
    - Divide by zero: DIV/DIVU give all-ones; REM/REMU give A.
    - Signed overflow (A = most-negative, B = -1): DIV gives A; REM gives 0.
- Illegal ops (any other opcode, undefined funct3 or funct7, or M op with ENABLE_M=0):
  - Latency 1, result_out=0, illegal_out=1.
- Backpressure: in DONE with result_ready_in=0, result_out, illegal_out and result_valid_out hold stable.
- Consume without new accept: DONE→IDLE, result_valid_out drops, and result_out holds its last value.
- Operand and decode inputs are sampled only at accept. Changes to them during BUSY or DONE have no effect.

Test Plan:
- Reset/idle: assert rst mid-DIV (10 cycles into BUSY) → next cycle result_valid_out=0, result_out=0, ready_out=1; a subsequent ADD 5+7 returns 12.
- RV32I sweep, back-to-back with result_ready_in=1:
  - SUB 3-5 → 0xFFFFFFFE.
  - SRAI 0x80000000 by 4 → 0xF8000000.
  - SLTU 1 vs 0xFFFFFFFF → 1.
  - BLT -1 vs 1 → 1.
  - All ops deliver one result per cycle.
- MUL/MULH: MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF; each valid exactly 33 cycles after accept, with ready_out=0 in between.
- Divide corners, all latency 1:
  - DIV 7/0 → 0xFFFFFFFF.
  - REMU 7/0 → 7.
  - DIV 0x80000000/-1 → 0x80000000.
  - REM same operands → 0.
- Divide normal: DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; latency 33.
- Backpressure and illegal:
  - Hold result_ready_in=0 for 5 cycles after an XOR result → result_out stable and ready_out=0.
  - Opcode 1111111 → illegal_out=1, result 0.
  - With ENABLE_M=0, MUL → illegal_out=1.
